// File: rtl/ppc_types.sv
// rtl/ppc_types.sv - shared decode and reservation-station record types
package ppc_types;

  localparam int PPC_GPR_ADDR_W = 5;
  localparam int PPC_DATA_W     = 32;
  localparam int PPC_RS_TAG_W   = 5;

  typedef struct packed {
    logic subtract;
    logic invert_op1;
    logic add_const;
    logic use_ca;
    logic set_ca;
    logic set_ov;
    logic set_cr0;
  } add_sub_decode_t;

  // Reference layouts at the default tag width; the station keeps
  // per-field arrays so its tag width can follow RS_ID_WIDTH.
  typedef struct packed {
    logic                    valid;
    logic [PPC_RS_TAG_W-1:0] tag;
    logic [PPC_DATA_W-1:0]   value;
  } rs_operand_t;

  typedef struct packed {
    logic                      busy;
    rs_operand_t               op1;
    rs_operand_t               op2;
    rs_operand_t               op3;
    logic [PPC_GPR_ADDR_W-1:0] result_reg_addr;
    add_sub_decode_t           control;
  } add_sub_rs_entry_t;

endpackage

// File: rtl/add_sub_rs_slot.sv
// rtl/add_sub_rs_slot.sv - one operand register with CDB tag-compare wakeup
module rs_operand_slot #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              busy,
  input  logic              load,
  input  logic              load_valid,
  input  logic [TAG_W-1:0]  load_tag,
  input  logic [DATA_W-1:0] load_value,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              valid,
  output logic [DATA_W-1:0] value
);

  logic [TAG_W-1:0] tag_q;
  logic             load_snoop;
  logic             wake;

  // A broadcast in the dispatch cycle is captured directly so it is never lost.
  assign load_snoop = ~load_valid & cdb_valid & (cdb_tag == load_tag);
  assign wake       = busy & ~valid & cdb_valid & (cdb_tag == tag_q);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      value <= '0;
      tag_q <= '0;
    end else if (load) begin
      tag_q <= load_tag;
      valid <= load_valid | load_snoop;
      value <= load_valid ? load_value : cdb_data;
    end else if (wake) begin
      valid <= 1'b1;
      value <= cdb_data;
    end
  end

endmodule

// File: rtl/add_sub_rs.sv
// rtl/add_sub_rs.sv - add/sub reservation station and issue scheduler
// Optional flush port enabled by defining ADD_SUB_RS_FLUSH_EN.
module add_sub_rs
  import ppc_types::*;
#(
  parameter int RS_DEPTH    = 4,
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_BASE_ID  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [4:0]             result_reg_addr_in,
  input  add_sub_decode_t        control,
  input  logic [31:0]            op1_value,
  input  logic [31:0]            op2_value,
  input  logic                   op1_valid,
  input  logic                   op2_valid,
  input  logic                   op3_valid,
  input  logic [RS_ID_WIDTH-1:0] op1_tag,
  input  logic [RS_ID_WIDTH-1:0] op2_tag,
  input  logic [RS_ID_WIDTH-1:0] op3_tag,
  input  logic                   op3_value,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_tag,
  input  logic [31:0]            cdb_data,
  input  logic                   cdb_ca,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [4:0]             issue_result_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output logic                   issue_carry,
  output add_sub_decode_t        issue_control
`ifdef ADD_SUB_RS_FLUSH_EN
  ,
  input  logic                   flush
`endif
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic [RS_DEPTH-1:0] busy;
  logic [RS_DEPTH-1:0] ready;
  logic [RS_DEPTH-1:0] load;
  logic [RS_DEPTH-1:0] v1, v2, v3;
  logic [31:0]         val1 [RS_DEPTH];
  logic [31:0]         val2 [RS_DEPTH];
  logic                val3 [RS_DEPTH];
  logic [4:0]          rra_q [RS_DEPTH];
  add_sub_decode_t     ctl_q [RS_DEPTH];

  logic             locked;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] ready_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             any_ready;
  logic             dispatch_fire;
  logic             issue_fire;
  logic             kill;

`ifdef ADD_SUB_RS_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign ready       = busy & v1 & v2 & v3;
  assign any_ready   = |ready;
  assign input_ready = ~rst & ~kill & ~(&busy);
  assign issue_valid = ~rst & ~kill & any_ready;

  // A locked entry stays ready until its handshake, so any_ready covers it.
  assign sel_idx       = locked ? lock_idx : ready_idx;
  assign dispatch_fire = input_valid & input_ready;
  assign issue_fire    = issue_valid & issue_ready;

  always_comb begin
    free_idx  = '0;
    ready_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy[i])  free_idx  = IDX_W'(i);
      if (ready[i])  ready_idx = IDX_W'(i);
    end
  end

  always_comb begin
    load = '0;
    if (dispatch_fire) load[free_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      busy     <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else begin
      locked   <= issue_valid & ~issue_ready;
      lock_idx <= sel_idx;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (issue_fire && sel_idx == IDX_W'(i)) busy[i] <= 1'b0;
        if (load[i]) busy[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (load[i]) begin
        rra_q[i] <= result_reg_addr_in;
        ctl_q[i] <= control;
      end
    end
  end

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_entry
    rs_operand_slot #(.DATA_W(32), .TAG_W(RS_ID_WIDTH)) u_op1 (
      .clk        (clk),
      .rst        (rst),
      .clear      (kill),
      .busy       (busy[g]),
      .load       (load[g]),
      .load_valid (op1_valid),
      .load_tag   (op1_tag),
      .load_value (op1_value),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .valid      (v1[g]),
      .value      (val1[g])
    );

    rs_operand_slot #(.DATA_W(32), .TAG_W(RS_ID_WIDTH)) u_op2 (
      .clk        (clk),
      .rst        (rst),
      .clear      (kill),
      .busy       (busy[g]),
      .load       (load[g]),
      .load_valid (op2_valid),
      .load_tag   (op2_tag),
      .load_value (op2_value),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .valid      (v2[g]),
      .value      (val2[g])
    );

    rs_operand_slot #(.DATA_W(1), .TAG_W(RS_ID_WIDTH)) u_op3 (
      .clk        (clk),
      .rst        (rst),
      .clear      (kill),
      .busy       (busy[g]),
      .load       (load[g]),
      .load_valid (op3_valid),
      .load_tag   (op3_tag),
      .load_value (op3_value),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_ca),
      .valid      (v3[g]),
      .value      (val3[g])
    );
  end

  always_comb begin
    issue_rs_id           = '0;
    issue_result_reg_addr = '0;
    issue_op1             = '0;
    issue_op2             = '0;
    issue_carry           = 1'b0;
    issue_control         = '0;
    if (issue_valid) begin
      issue_rs_id           = RS_ID_WIDTH'(RS_BASE_ID) + RS_ID_WIDTH'(sel_idx);
      issue_result_reg_addr = rra_q[sel_idx];
      issue_op1             = val1[sel_idx];
      issue_op2             = val2[sel_idx];
      issue_carry           = val3[sel_idx];
      issue_control         = ctl_q[sel_idx];
    end
  end

endmodule

// File: tb/tb_add_sub_rs.sv
// tb/tb_add_sub_rs.sv - self-checking bench for add_sub_rs
// Covers ADD_SUB_RS_FLUSH_EN when that macro is defined.
module tb_add_sub_rs;
  import ppc_types::*;

  localparam int DEPTH = 4;
  localparam int IDW   = 5;
  localparam int BASE  = 0;
  localparam int CW    = $bits(add_sub_decode_t);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, input_valid, input_ready;
  logic [4:0]      result_reg_addr_in;
  add_sub_decode_t control;
  logic [31:0]     op1_value, op2_value;
  logic            op1_valid, op2_valid, op3_valid, op3_value;
  logic [IDW-1:0]  op1_tag, op2_tag, op3_tag;
  logic            cdb_valid, cdb_ca;
  logic [IDW-1:0]  cdb_tag;
  logic [31:0]     cdb_data;
  logic            issue_valid, issue_ready, issue_carry;
  logic [IDW-1:0]  issue_rs_id;
  logic [4:0]      issue_result_reg_addr;
  logic [31:0]     issue_op1, issue_op2;
  add_sub_decode_t issue_control;
`ifdef ADD_SUB_RS_FLUSH_EN
  logic            flush;
`endif

  add_sub_rs #(.RS_DEPTH(DEPTH), .RS_ID_WIDTH(IDW), .RS_BASE_ID(BASE)) dut (
    .clk(clk), .rst(rst), .input_valid(input_valid), .input_ready(input_ready),
    .result_reg_addr_in(result_reg_addr_in), .control(control),
    .op1_value(op1_value), .op2_value(op2_value),
    .op1_valid(op1_valid), .op2_valid(op2_valid), .op3_valid(op3_valid),
    .op1_tag(op1_tag), .op2_tag(op2_tag), .op3_tag(op3_tag), .op3_value(op3_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_ca(cdb_ca),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
    .issue_result_reg_addr(issue_result_reg_addr), .issue_op1(issue_op1),
    .issue_op2(issue_op2), .issue_carry(issue_carry), .issue_control(issue_control)
`ifdef ADD_SUB_RS_FLUSH_EN
    , .flush(flush)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a table of pending instructions, each with its operands.
  typedef struct packed {
    logic                busy;
    logic [2:0]          v;
    logic [2:0][IDW-1:0] tag;
    logic [2:0][31:0]    val;
    logic [4:0]          rra;
    logic [CW-1:0]       ctl;
  } m_entry_t;

  m_entry_t m [DEPTH];
  bit       m_locked;
  int       m_lock;

  function automatic bit fl();
`ifdef ADD_SUB_RS_FLUSH_EN
    return flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < DEPTH; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_sel();
    if (m_locked) return m_lock;
    for (int i = 0; i < DEPTH; i++) if (m[i].busy && (&m[i].v)) return i;
    return -1;
  endfunction

  task automatic model_check();
    int sel;
    bit eiv, eir;
    sel = m_sel();
    eiv = !rst && !fl() && (sel >= 0);
    eir = !rst && !fl() && !m_full();
    check("m_input_ready", 32'(input_ready), 32'(eir));
    check("m_issue_valid", 32'(issue_valid), 32'(eiv));
    if (eiv) begin
      check("m_rs_id", 32'(issue_rs_id), 32'(BASE + sel));
      check("m_op1", issue_op1, m[sel].val[0]);
      check("m_op2", issue_op2, m[sel].val[1]);
      check("m_carry", 32'(issue_carry), 32'(m[sel].val[2][0]));
      check("m_rra", 32'(issue_result_reg_addr), 32'(m[sel].rra));
      check("m_ctl", 32'(issue_control), 32'(m[sel].ctl));
    end else if (rst) begin
      check("m_rst_op1", issue_op1, 32'd0);
      check("m_rst_id", 32'(issue_rs_id), 32'd0);
    end
  endtask

  task automatic set_op(input int e, input int k, input logic v, input logic [IDW-1:0] t,
                        input logic [31:0] val, input logic [31:0] snoop);
    m[e].tag[k] = t;
    if (v) begin
      m[e].v[k] = 1'b1; m[e].val[k] = val;
    end else if (cdb_valid && t == cdb_tag) begin
      m[e].v[k] = 1'b1; m[e].val[k] = snoop;
    end else begin
      m[e].v[k] = 1'b0; m[e].val[k] = '0;
    end
  endtask

  task automatic model_update();
    int sel, fr;
    bit ir;
    if (rst || fl()) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
      m_locked = 1'b0;
      return;
    end
    sel = m_sel();
    ir  = !m_full();
    fr  = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].busy) fr = i;
    for (int i = 0; i < DEPTH; i++)
      for (int k = 0; k < 3; k++)
        if (m[i].busy && !m[i].v[k] && cdb_valid && m[i].tag[k] == cdb_tag) begin
          m[i].v[k]   = 1'b1;
          m[i].val[k] = (k == 2) ? {31'b0, cdb_ca} : cdb_data;
        end
    if (sel >= 0 && issue_ready) m[sel].busy = 1'b0;
    m_locked = (sel >= 0) && !issue_ready;
    m_lock   = sel;
    if (input_valid && ir) begin
      m[fr].busy = 1'b1;
      m[fr].rra  = result_reg_addr_in;
      m[fr].ctl  = control;
      set_op(fr, 0, op1_valid, op1_tag, op1_value, cdb_data);
      set_op(fr, 1, op2_valid, op2_tag, op2_value, cdb_data);
      set_op(fr, 2, op3_valid, op3_tag, {31'b0, op3_value}, {31'b0, cdb_ca});
    end
  endtask

  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic disp(input logic [31:0] a, input logic av, input logic [IDW-1:0] at,
                      input logic [31:0] b, input logic bv, input logic [IDW-1:0] bt,
                      input logic c, input logic cv, input logic [IDW-1:0] ct,
                      input logic [4:0] rra);
    logic [CW-1:0] cbits;
    cbits = CW'($urandom);
    input_valid = 1'b1;
    op1_value = a; op1_valid = av; op1_tag = at;
    op2_value = b; op2_valid = bv; op2_tag = bt;
    op3_value = c; op3_valid = cv; op3_tag = ct;
    result_reg_addr_in = rra;
    control = cbits;
  endtask

  typedef struct packed {
    logic [31:0]    op1;
    logic [31:0]    op2;
    logic           carry;
    logic [4:0]     rra;
    logic [31:0]    exp_op1;
    logic [31:0]    exp_op2;
    logic           exp_carry;
    logic [IDW-1:0] exp_id;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{32'd89, 32'd187, 1'b0, 5'd3, 32'd89, 32'd187, 1'b0, 5'd0};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd0};
    vecs[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 5'd0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 5'd0};
    vecs[3] = '{32'd0, 32'd0, 1'b1, 5'd17, 32'd0, 32'd0, 1'b1, 5'd0};

    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    m_locked = 1'b0; m_lock = 0;
    rst = 1'b1; input_valid = 1'b0; issue_ready = 1'b0; control = '0;
    result_reg_addr_in = '0; op1_value = '0; op2_value = '0; op3_value = 1'b0;
    op1_valid = 1'b0; op2_valid = 1'b0; op3_valid = 1'b0;
    op1_tag = '0; op2_tag = '0; op3_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_ca = 1'b0;
`ifdef ADD_SUB_RS_FLUSH_EN
    flush = 1'b0;
`endif
    @(negedge clk); #1;
    tick(); tick();
    check("rst_input_ready", 32'(input_ready), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_op1", issue_op1, 32'd0);
    rst = 1'b0; #1;
    check("ready_after_reset", 32'(input_ready), 32'd1);

    // Basic issue, table driven
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      disp(vecs[i].op1, 1'b1, '0, vecs[i].op2, 1'b1, '0, vecs[i].carry, 1'b1, '0, vecs[i].rra);
      tick();
      input_valid = 1'b0;
      check("basic_valid", 32'(issue_valid), 32'd1);
      check("basic_id", 32'(issue_rs_id), 32'(vecs[i].exp_id));
      check("basic_op1", issue_op1, vecs[i].exp_op1);
      check("basic_op2", issue_op2, vecs[i].exp_op2);
      check("basic_carry", 32'(issue_carry), 32'(vecs[i].exp_carry));
      check("basic_rra", 32'(issue_result_reg_addr), 32'(vecs[i].rra));
      tick();
      check("basic_freed", 32'(issue_valid), 32'd0);
    end

    // Fill and stall
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp(32'(100 + k), 1'b1, '0, 32'd1, 1'b1, '0, 1'b0, 1'b1, '0, 5'(k));
      tick();
    end
    disp(32'd999, 1'b1, '0, 32'd1, 1'b1, '0, 1'b0, 1'b1, '0, 5'd9);
    check("full_ready", 32'(input_ready), 32'd0);
    check("full_id", 32'(issue_rs_id), 32'd0);
    tick();
    check("full_hold_ready", 32'(input_ready), 32'd0);
    check("stall_hold_op1", issue_op1, 32'd100);
    input_valid = 1'b0;
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 32'(issue_valid), 32'd1);
      check("drain_id", 32'(issue_rs_id), 32'(BASE + k));
      check("drain_op1", issue_op1, 32'(100 + k));
      tick();
    end
    check("drain_empty", 32'(issue_valid), 32'd0);

    // CDB wakeup, with a non-matching tag first
    disp(32'd0, 1'b0, 5'd7, 32'd5, 1'b1, '0, 1'b0, 1'b1, '0, 5'd9);
    tick();
    input_valid = 1'b0;
    check("wake_wait", 32'(issue_valid), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'd123;
    tick();
    check("tag_ignored", 32'(issue_valid), 32'd0);
    cdb_tag = 5'd7; cdb_data = 32'h7FFF_FFFE;
    tick();
    cdb_valid = 1'b0;
    check("wake_valid", 32'(issue_valid), 32'd1);
    check("wake_op1", issue_op1, 32'h7FFF_FFFE);
    check("wake_op2", issue_op2, 32'd5);
    tick();
    check("wake_freed", 32'(issue_valid), 32'd0);

    // Dispatch-time snoop of the carry
    disp(32'd11, 1'b1, '0, 32'd22, 1'b1, '0, 1'b0, 1'b0, 5'd3, 5'd4);
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_ca = 1'b1; cdb_data = 32'd0;
    tick();
    input_valid = 1'b0; cdb_valid = 1'b0; cdb_ca = 1'b0;
    check("snoop_valid", 32'(issue_valid), 32'd1);
    check("snoop_carry", 32'(issue_carry), 32'd1);
    tick();
    check("snoop_freed", 32'(issue_valid), 32'd0);

    // Stall lock holds entry 2 while entry 0 wakes
    issue_ready = 1'b0;
    disp(32'd0, 1'b0, 5'd4, 32'd1, 1'b1, '0, 1'b0, 1'b1, '0, 5'd1);
    tick();
    disp(32'd0, 1'b0, 5'd6, 32'd2, 1'b1, '0, 1'b0, 1'b1, '0, 5'd2);
    tick();
    disp(32'd222, 1'b1, '0, 32'd3, 1'b1, '0, 1'b1, 1'b1, '0, 5'd3);
    tick();
    input_valid = 1'b0;
    check("lock_sel_id", 32'(issue_rs_id), 32'd2);
    cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_data = 32'd44;
    tick();
    cdb_valid = 1'b0;
    check("lock_hold_id", 32'(issue_rs_id), 32'd2);
    check("lock_hold_op1", issue_op1, 32'd222);
    check("lock_hold_rra", 32'(issue_result_reg_addr), 32'd3);
    issue_ready = 1'b1;
    tick();
    check("after_lock_id", 32'(issue_rs_id), 32'd0);
    check("after_lock_op1", issue_op1, 32'd44);
    tick();
    check("entry1_waits", 32'(issue_valid), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_data = 32'd66;
    tick();
    cdb_valid = 1'b0;
    check("entry1_id", 32'(issue_rs_id), 32'd1);
    check("entry1_op1", issue_op1, 32'd66);
    tick();
    check("lock_seq_empty", 32'(issue_valid), 32'd0);

    // Reset with three entries pending
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp(32'(7 + k), 1'b1, '0, 32'd1, 1'b1, '0, 1'b0, 1'b1, '0, 5'(k));
      tick();
    end
    input_valid = 1'b0;
    check("pre_reset_valid", 32'(issue_valid), 32'd1);
    rst = 1'b1; #1;
    check("rst_comb_valid", 32'(issue_valid), 32'd0);
    tick();
    rst = 1'b0; issue_ready = 1'b1; #1;
    check("post_reset_valid", 32'(issue_valid), 32'd0);
    check("post_reset_ready", 32'(input_ready), 32'd1);
    tick(); tick();
    check("no_stale_issue", 32'(issue_valid), 32'd0);

`ifdef ADD_SUB_RS_FLUSH_EN
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp(32'(50 + k), 1'b1, '0, 32'd1, 1'b1, '0, 1'b0, 1'b1, '0, 5'(k));
      tick();
    end
    flush = 1'b1; #1;
    check("flush_comb_valid", 32'(issue_valid), 32'd0);
    check("flush_comb_ready", 32'(input_ready), 32'd0);
    tick();
    input_valid = 1'b0; flush = 1'b0; issue_ready = 1'b1; #1;
    check("post_flush_valid", 32'(issue_valid), 32'd0);
    tick(); tick();
    check("no_stale_after_flush", 32'(issue_valid), 32'd0);
`endif

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst         = ($urandom_range(0, 299) == 0);
      input_valid = $urandom_range(0, 1) == 1;
      disp($urandom, $urandom_range(0, 2) != 0, IDW'($urandom_range(0, 7)),
           $urandom, $urandom_range(0, 2) != 0, IDW'($urandom_range(0, 7)),
           1'($urandom), $urandom_range(0, 2) != 0, IDW'($urandom_range(0, 7)),
           5'($urandom));
      input_valid = $urandom_range(0, 1) == 1;
      cdb_valid   = $urandom_range(0, 9) < 4;
      cdb_tag     = IDW'($urandom_range(0, 7));
      cdb_data    = $urandom;
      cdb_ca      = 1'($urandom);
      issue_ready = $urandom_range(0, 9) < 6;
`ifdef ADD_SUB_RS_FLUSH_EN
      flush       = ($urandom_range(0, 149) == 0);
`endif
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
